ysyx_201979054_icache_refill: RTL and testbench

Refill engine directly upstream of the direct-mapped instruction cache. On a fetch miss it issues one burst read on the memory read channel, assembles the returned beats into a full 512-bit cache line, and presents the line with a one-cycle write strobe to the cache's write port. Bus errors, protocol violations and instruction invalidates during a refill suppress the cache write.

---
 rtl/ysyx_201979054_icache_refill_pkg.sv | 21 ++
 rtl/ysyx_201979054_icache_refill.sv | 113 +++++++++++
 tb/tb_ysyx_201979054_icache_refill.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_201979054_icache_refill_pkg.sv
// Shared types and derived sizes for the I-cache refill engine.
// Defaults describe a 512-bit line filled by 64-bit beats.
package ysyx_201979054_icache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int DEF_BLOCK_WIDTH = 512;
  localparam int DEF_BEAT_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH  = 64;

  localparam int BEATS = DEF_BLOCK_WIDTH / DEF_BEAT_WIDTH;
  localparam int OFF_W = $clog2(DEF_BLOCK_WIDTH / 8);

endpackage

// File: rtl/ysyx_201979054_icache_refill.sv
// I-cache refill engine: one burst read per miss, line assembly,
// single-cycle cache write strobe or access-fault pulse.
module ysyx_201979054_icache_refill
  import ysyx_201979054_icache_refill_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
  input  logic                   i_invalidate_instr,
  output logic                   o_busy,
  output logic                   o_mem_ar_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_ar_addr,
  output logic [7:0]             o_mem_ar_len,
  input  logic                   i_mem_ar_ready,
  input  logic                   i_mem_r_valid,
  input  logic [BEAT_WIDTH-1:0]  i_mem_r_data,
  input  logic                   i_mem_r_last,
  input  logic [1:0]             i_mem_r_resp,
  output logic                   o_mem_r_ready,
  output logic                   o_write_en,
  output logic [BLOCK_WIDTH-1:0] o_line,
  output logic                   o_access_fault
);

  localparam int NBEATS = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int OW     = $clog2(BLOCK_WIDTH / 8);
  localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OW){1'b1}}, {OW{1'b0}}};

  state_e          state, next;
  logic [KW-1:0]   k;
  logic            err, cancel;
  logic            beat, last_k;

  assign beat   = (state == DATA) && i_mem_r_valid;
  assign last_k = (k == KW'(NBEATS-1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next           = state;
    o_busy         = 1'b1;
    o_mem_ar_valid = 1'b0;
    o_mem_r_ready  = 1'b0;
    o_write_en     = 1'b0;
    o_access_fault = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_req) next = ADDR;
      end
      ADDR: begin
        o_mem_ar_valid = 1'b1;
        if (i_mem_ar_ready) next = DATA;
      end
      DATA: begin
        o_mem_r_ready = 1'b1;
        if (i_mem_r_valid && (last_k || i_mem_r_last)) next = DONE;
      end
      DONE: begin
        // invalidate in this very cycle still kills the write
        o_write_en     = !err && !cancel && !i_invalidate_instr;
        o_access_fault = err;
        next           = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_mem_ar_addr <= '0;
      o_mem_ar_len  <= '0;
      o_line        <= '0;
      k             <= '0;
      err           <= 1'b0;
      cancel        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (i_req) begin
          o_mem_ar_addr <= i_miss_addr & LINE_MASK;
          o_mem_ar_len  <= 8'(NBEATS-1);
          k             <= '0;
          err           <= 1'b0;
          cancel        <= 1'b0;
        end
      end else if (i_invalidate_instr) begin
        cancel <= 1'b1;
      end
      if (beat) begin
        for (int i = 0; i < NBEATS; i++) begin
          if (k == KW'(i))
            o_line[i*BEAT_WIDTH +: BEAT_WIDTH] <= i_mem_r_data;
        end
        k <= k + KW'(1);
        // premature or missing r_last is a protocol error
        if (i_mem_r_resp != RESP_OKAY || (last_k != i_mem_r_last))
          err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_201979054_icache_refill.sv
// Bench for the I-cache refill engine: vector table, hand sequences,
// random bursts against a behavioural outcome model.
module tb_ysyx_201979054_icache_refill;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         i_req = 1'b0;
  logic [63:0]  i_miss_addr = '0;
  logic         i_invalidate_instr = 1'b0;
  logic         o_busy;
  logic         o_mem_ar_valid;
  logic [63:0]  o_mem_ar_addr;
  logic [7:0]   o_mem_ar_len;
  logic         i_mem_ar_ready = 1'b0;
  logic         i_mem_r_valid = 1'b0;
  logic [63:0]  i_mem_r_data = '0;
  logic         i_mem_r_last = 1'b0;
  logic [1:0]   i_mem_r_resp = 2'b00;
  logic         o_mem_r_ready;
  logic         o_write_en;
  logic [511:0] o_line;
  logic         o_access_fault;

  ysyx_201979054_icache_refill dut (
    .clk(clk),
    .arst(arst),
    .i_req(i_req),
    .i_miss_addr(i_miss_addr),
    .i_invalidate_instr(i_invalidate_instr),
    .o_busy(o_busy),
    .o_mem_ar_valid(o_mem_ar_valid),
    .o_mem_ar_addr(o_mem_ar_addr),
    .o_mem_ar_len(o_mem_ar_len),
    .i_mem_ar_ready(i_mem_ar_ready),
    .i_mem_r_valid(i_mem_r_valid),
    .i_mem_r_data(i_mem_r_data),
    .i_mem_r_last(i_mem_r_last),
    .i_mem_r_resp(i_mem_r_resp),
    .o_mem_r_ready(o_mem_r_ready),
    .o_write_en(o_write_en),
    .o_line(o_line),
    .o_access_fault(o_access_fault)
  );

  always #5 clk = ~clk;

  // eb: error beat (>7 none); lb: beat carrying r_last (7 normal);
  // ib: invalidate beat (8 = during DONE, >8 none)
  typedef struct {
    logic [63:0] addr;
    int          ard;
    bit          gap;
    int          eb;
    int          lb;
    int          ib;
    bit          ew;
    bit          ef;
    int          enb;
  } vec_t;

  vec_t         tab [8];
  int           errs = 0;
  int           checks = 0;
  logic [63:0]  mline [8];
  logic [511:0] last_line;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic logic [511:0] pack_line();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = mline[i];
    return r;
  endfunction

  function automatic void model(input int eb, input int lb, input int ib,
                                output bit ew, output bit ef,
                                output int enb);
    int nb;
    bit er, cn;
    nb  = (lb < 7) ? lb + 1 : 8;
    er  = (eb < nb) || (lb < 7);
    cn  = (ib < nb) || (ib == 8);
    ew  = !er && !cn;
    ef  = er;
    enb = nb;
  endfunction

  task automatic run(input vec_t v, input bit seq, input bit timing);
    int          cyc, b, nw, nf, busy_n, wcyc, bend;
    bit          done, rv, in_data, in_done;
    logic [63:0] word, exp_addr;
    exp_addr = v.addr & ~64'h3f;
    bend = (v.lb < 7) ? v.lb : 7;
    b = 0; nw = 0; nf = 0; busy_n = 0; wcyc = -1; done = 0;
    @(negedge clk);
    i_req = 1'b1;
    i_miss_addr = v.addr;
    #1;
    chk("busy_at_req", 512'(o_busy), 512'(0));
    @(negedge clk);
    i_req = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      in_data = o_mem_r_ready;
      in_done = o_busy && !o_mem_ar_valid && !o_mem_r_ready;
      word = seq ? 64'(b) : {$urandom, $urandom};
      rv = in_data && (b <= bend) && (!v.gap || (cyc % 2 == 0));
      i_mem_ar_ready = o_mem_ar_valid && (cyc - 1 >= v.ard);
      i_mem_r_valid = rv;
      i_mem_r_data = rv ? word : '0;
      i_mem_r_last = rv && (b == bend);
      i_mem_r_resp = (rv && b == v.eb) ? 2'b10 : 2'b00;
      i_invalidate_instr = (rv && b == v.ib) || (v.ib == 8 && in_done);
      #1;
      if (o_busy) busy_n++;
      if (o_mem_ar_valid) begin
        chk("ar_addr", 512'(o_mem_ar_addr), 512'(exp_addr));
        chk("ar_len", 512'(o_mem_ar_len), 512'(7));
      end
      if (o_write_en) begin
        nw++;
        wcyc = cyc;
      end
      if (o_access_fault) nf++;
      if (in_done) begin
        last_line = o_line;
        chk("line", o_line, pack_line());
        done = 1;
      end
      if (rv) begin
        mline[b] = word;
        b++;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("timeout", 512'(0), 512'(1));
    i_mem_ar_ready = 1'b0;
    i_mem_r_valid = 1'b0;
    i_mem_r_last = 1'b0;
    i_mem_r_resp = 2'b00;
    i_invalidate_instr = 1'b0;
    #1;
    chk("idle_after_done", 512'({o_busy, o_write_en}), 512'(0));
    chk("writes", 512'(nw), 512'(v.ew));
    chk("faults", 512'(nf), 512'(v.ef));
    chk("beats", 512'(b), 512'(v.enb));
    if (timing) begin
      chk("write_cycle", 512'(wcyc), 512'(10));
      chk("busy_cycles", 512'(busy_n), 512'(10));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 512'(o_busy), 512'(0));
    chk({tag, "_ar_valid"}, 512'(o_mem_ar_valid), 512'(0));
    chk({tag, "_ar_addr"}, 512'(o_mem_ar_addr), 512'(0));
    chk({tag, "_ar_len"}, 512'(o_mem_ar_len), 512'(0));
    chk({tag, "_r_ready"}, 512'(o_mem_r_ready), 512'(0));
    chk({tag, "_write_en"}, 512'(o_write_en), 512'(0));
    chk({tag, "_fault"}, 512'(o_access_fault), 512'(0));
    chk({tag, "_line"}, o_line, 512'(0));
  endtask

  initial begin
    vec_t r;
    tab[0] = '{64'h8000_2fc8, 3, 1, 15, 7, 15, 1, 0, 8};
    tab[1] = '{64'h0000_1000, 0, 0,  3, 7, 15, 0, 1, 8};
    tab[2] = '{64'h0000_2040, 0, 0, 15, 5, 15, 0, 1, 6};
    tab[3] = '{64'h0000_3000, 0, 0, 15, 7, 15, 1, 0, 8};
    tab[4] = '{64'h0000_4010, 1, 0, 15, 7,  4, 0, 0, 8};
    tab[5] = '{64'h0000_5000, 0, 1, 15, 7,  8, 0, 0, 8};
    tab[6] = '{64'h0000_6abc, 2, 0,  2, 7,  1, 0, 1, 8};
    tab[7] = '{64'hffff_ffff, 0, 1,  7, 7, 15, 0, 1, 8};
    for (int i = 0; i < 8; i++) mline[i] = '0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst = 1'b0;

    run('{64'h8000_0124, 0, 0, 15, 7, 15, 1, 0, 8}, 1'b1, 1'b1);
    chk("line_lo", 512'(last_line[63:0]), 512'(0));
    chk("line_hi", 512'(last_line[511:448]), 512'(7));

    for (int i = 0; i < 8; i++) run(tab[i], 1'b0, 1'b0);

    // reset in the middle of the data phase
    @(negedge clk);
    i_req = 1'b1;
    i_miss_addr = 64'h6000_0040;
    @(negedge clk);
    i_req = 1'b0;
    i_mem_ar_ready = 1'b1;
    @(negedge clk);
    i_mem_ar_ready = 1'b0;
    i_mem_r_valid = 1'b1;
    i_mem_r_data = 64'hdead_beef_0000_0001;
    repeat (3) @(negedge clk);
    #1;
    arst = 1'b1;
    #1;
    check_all_zero("midrst");
    i_mem_r_valid = 1'b0;
    i_mem_r_data = '0;
    for (int i = 0; i < 8; i++) mline[i] = '0;
    @(negedge clk);
    arst = 1'b0;
    run('{64'h8000_0124, 0, 0, 15, 7, 15, 1, 0, 8}, 1'b1, 1'b1);

    for (int n = 0; n < 24; n++) begin
      r.addr = {$urandom, $urandom};
      r.ard = int'($urandom_range(0, 3));
      r.gap = 1'($urandom_range(0, 1));
      r.eb = int'($urandom_range(0, 15));
      r.lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 7;
      r.ib = int'($urandom_range(0, 15));
      model(r.eb, r.lb, r.ib, r.ew, r.ef, r.enb);
      run(r, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
